// File: rtl/mem_access_stage_if.sv
// Memory-stage bus: EX/MEM-side request fields in, MEM/WB-side results out.
// stallCycles/missAlignCount exist only when MEM_PERF_COUNT_EN is defined.
interface mem_access_stage_if;
  logic [31:0] aluResult;
  logic [31:0] writeData;
  logic [4:0]  muxRegFileData;
  logic        regWrite;
  logic        memToReg;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  memSize;
  logic        memSigned;
  logic [31:0] readData;
  logic [31:0] outAluResult;
  logic [4:0]  outmuxRegFileData;
  logic        outRegWrite;
  logic        outMemToReg;
  logic        stall;
  logic        misaligned;
`ifdef MEM_PERF_COUNT_EN
  logic [31:0] stallCycles;
  logic [7:0]  missAlignCount;

  modport master (
    output aluResult, writeData, muxRegFileData, regWrite, memToReg,
           memRead, memWrite, memSize, memSigned,
    input  readData, outAluResult, outmuxRegFileData, outRegWrite, outMemToReg,
           stall, misaligned, stallCycles, missAlignCount
  );
  modport slave (
    input  aluResult, writeData, muxRegFileData, regWrite, memToReg,
           memRead, memWrite, memSize, memSigned,
    output readData, outAluResult, outmuxRegFileData, outRegWrite, outMemToReg,
           stall, misaligned, stallCycles, missAlignCount
  );
`else
  modport master (
    output aluResult, writeData, muxRegFileData, regWrite, memToReg,
           memRead, memWrite, memSize, memSigned,
    input  readData, outAluResult, outmuxRegFileData, outRegWrite, outMemToReg,
           stall, misaligned
  );
  modport slave (
    input  aluResult, writeData, muxRegFileData, regWrite, memToReg,
           memRead, memWrite, memSize, memSigned,
    output readData, outAluResult, outmuxRegFileData, outRegWrite, outMemToReg,
           stall, misaligned
  );
`endif
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage with byte-addressable data memory; non-memory ops take 1 cycle, memory ops LATENCY+1.
// stall (combinational) freezes upstream for LATENCY cycles per access; MEM_PERF_COUNT_EN adds counters.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [31:0] mem [DEPTH_WORDS];

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d, wdat_q, wdat_d;
  logic [4:0]     rd_q, rd_d;
  logic           rw_q, rw_d, m2r_q, m2r_d, rdreq_q, rdreq_d, wrreq_q, wrreq_d, sgn_q, sgn_d;
  logic [1:0]     size_q, size_d;
  logic [31:0]    rdata_q, rdata_d, alu_out_q, alu_out_d;
  logic [4:0]     rd_out_q, rd_out_d;
  logic           rw_out_q, rw_out_d, m2r_out_q, m2r_out_d, mis_q, mis_d;

  logic           mem_op, misal, stall_c, mis_evt, mem_we, done;
  logic [31:0]    word_rd, load_v, st_word;
  logic [7:0]     byte_v;
  logic [15:0]    half_v;

  assign mem_op  = bus.memRead | bus.memWrite;
  assign misal   = (bus.memSize == 2'b01) ? bus.aluResult[0] :
                   (bus.memSize[1]        ? (bus.aluResult[1:0] != 2'b00) : 1'b0);
  assign done    = (state_q == S_WAIT) && (cnt_q == '0);
  assign mis_evt = (state_q == S_IDLE) && mem_op && misal;
  assign stall_c = ~rst & ((state_q == S_IDLE) ? (mem_op & ~misal) : (cnt_q != '0));
  assign mem_we  = done && wrreq_q;

  // Lane extraction and store merge both work on the captured access.
  always_comb begin
    word_rd = mem[addr_q[AW+1:2]];
    byte_v  = word_rd[{addr_q[1:0], 3'b000} +: 8];
    half_v  = word_rd[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_v = {{24{sgn_q & byte_v[7]}}, byte_v};
      2'b01:   load_v = {{16{sgn_q & half_v[15]}}, half_v};
      default: load_v = word_rd;
    endcase
    st_word = word_rd;
    case (size_q)
      2'b00:   st_word[{addr_q[1:0], 3'b000} +: 8] = wdat_q[7:0];
      2'b01:   st_word[{addr_q[1], 4'b0000} +: 16] = wdat_q[15:0];
      default: st_word = wdat_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q[AW+1:2]] <= st_word;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    rd_d      = rd_q;
    rw_d      = rw_q;
    m2r_d     = m2r_q;
    rdreq_d   = rdreq_q;
    wrreq_d   = wrreq_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    rdata_d   = rdata_q;
    alu_out_d = alu_out_q;
    rd_out_d  = rd_out_q;
    rw_out_d  = rw_out_q;
    m2r_out_d = m2r_out_q;
    mis_d     = mis_q;
    case (state_q)
      S_IDLE: begin
        rdata_d = '0;
        if (!mem_op) begin
          alu_out_d = bus.aluResult;
          rd_out_d  = bus.muxRegFileData;
          rw_out_d  = bus.regWrite;
          m2r_out_d = bus.memToReg;
        end else if (misal) begin
          mis_d     = 1'b1;
          alu_out_d = bus.aluResult;
          rd_out_d  = bus.muxRegFileData;
          rw_out_d  = 1'b0;
          m2r_out_d = 1'b0;
        end else begin
          state_d   = S_WAIT;
          cnt_d     = CNT_INIT;
          addr_d    = bus.aluResult;
          wdat_d    = bus.writeData;
          rd_d      = bus.muxRegFileData;
          rw_d      = bus.regWrite;
          m2r_d     = bus.memToReg;
          rdreq_d   = bus.memRead;
          wrreq_d   = bus.memWrite;
          size_d    = bus.memSize;
          sgn_d     = bus.memSigned;
          rw_out_d  = 1'b0;
          m2r_out_d = 1'b0;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - 1'b1;
          rdata_d   = '0;
          rw_out_d  = 1'b0;
          m2r_out_d = 1'b0;
        end else begin
          state_d   = S_IDLE;
          alu_out_d = addr_q;
          rd_out_d  = rd_q;
          rw_out_d  = rw_q;
          m2r_out_d = m2r_q;
          // A store wins over a simultaneous load.
          rdata_d   = (wrreq_q || !rdreq_q) ? 32'h0 : load_v;
        end
      end
    endcase
  end

`ifdef MEM_PERF_COUNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [7:0]  miss_cnt_q, miss_cnt_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    miss_cnt_d     = miss_cnt_q;
    if (stall_c) stall_cycles_d = stall_cycles_q + 32'd1;
    if (mis_evt && miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
  end

  assign bus.stallCycles    = stall_cycles_q;
  assign bus.missAlignCount = miss_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      m2r_q     <= 1'b0;
      rdreq_q   <= 1'b0;
      wrreq_q   <= 1'b0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      rdata_q   <= '0;
      alu_out_q <= '0;
      rd_out_q  <= '0;
      rw_out_q  <= 1'b0;
      m2r_out_q <= 1'b0;
      mis_q     <= 1'b0;
`ifdef MEM_PERF_COUNT_EN
      stall_cycles_q <= '0;
      miss_cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      m2r_q     <= m2r_d;
      rdreq_q   <= rdreq_d;
      wrreq_q   <= wrreq_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      rdata_q   <= rdata_d;
      alu_out_q <= alu_out_d;
      rd_out_q  <= rd_out_d;
      rw_out_q  <= rw_out_d;
      m2r_out_q <= m2r_out_d;
      mis_q     <= mis_d;
`ifdef MEM_PERF_COUNT_EN
      stall_cycles_q <= stall_cycles_d;
      miss_cnt_q     <= miss_cnt_d;
`endif
    end
  end

  assign bus.readData          = rdata_q;
  assign bus.outAluResult      = alu_out_q;
  assign bus.outmuxRegFileData = rd_out_q;
  assign bus.outRegWrite       = rw_out_q;
  assign bus.outMemToReg       = m2r_out_q;
  assign bus.misaligned        = mis_q;
  assign bus.stall             = stall_c;
endmodule
